// File: rtl/bus_req_arbiter.sv
// bus_req_arbiter: round-robin merge of NUM_MASTERS buffered bus channels onto one CSR port with response timeout
module bus_req_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_req_is_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_biten,
  output logic [NUM_MASTERS-1:0]            m_pending,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rd_data,
  output logic                              s_bus_req,
  output logic                              s_bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]             s_bus_addr,
  output logic [DATA_WIDTH-1:0]             s_bus_wr_data,
  output logic [DATA_WIDTH-1:0]             s_bus_wr_biten,
  input  logic                              s_bus_ready,
  input  logic                              s_bus_err,
  input  logic [DATA_WIDTH-1:0]             s_bus_rd_data
);
  localparam int N  = NUM_MASTERS;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = $clog2(N);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]    state;
  logic [N-1:0]  pending, buf_wr, clr, acc;
  logic [AW-1:0] buf_addr [N];
  logic [DW-1:0] buf_wd [N];
  logic [DW-1:0] buf_be [N];
  logic [PW-1:0] rr_ptr, grant, nxt;
  logic          found, done, timed_out, resp_err;
  logic [CW-1:0] cnt;
  logic [DW-1:0] resp_data;
  int            j;
  assign timed_out = (TIMEOUT_CYCLES != 0) && state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done      = (state == ISSUE || state == WAIT) && (s_bus_ready || timed_out);
  assign clr       = done ? N'(1) << grant : '0;
  // a strobe landing on the completing edge refills the slot (set wins over clear)
  assign acc       = m_req & (~pending | clr);
  assign m_pending = pending;
  assign s_bus_req = state == ISSUE;
  assign m_ready   = state == RESP ? N'(1) << grant : '0;
  assign m_err     = resp_err ? m_ready : '0;
  always_comb begin
    m_rd_data = '0;
    if (state == RESP) m_rd_data[int'(grant)*DW +: DW] = resp_data;
  end
  always_comb begin
    found = 1'b0;
    nxt   = rr_ptr;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (!found && pending[j[PW-1:0]]) begin
        found = 1'b1;
        nxt   = j[PW-1:0];
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        buf_wr[i]   <= m_req_is_wr[i];
        buf_addr[i] <= m_addr[i*AW +: AW];
        buf_wd[i]   <= m_wr_data[i*DW +: DW];
        buf_be[i]   <= m_wr_biten[i*DW +: DW];
      end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      pending         <= '0;
      rr_ptr          <= PW'(N - 1);
      grant           <= '0;
      cnt             <= '0;
      resp_err        <= 1'b0;
      resp_data       <= '0;
      s_bus_req_is_wr <= 1'b0;
      s_bus_addr      <= '0;
      s_bus_wr_data   <= '0;
      s_bus_wr_biten  <= '0;
    end else begin
      pending <= (pending & ~clr) | acc;
      if (done) begin
        resp_err  <= s_bus_ready ? s_bus_err : 1'b1;
        resp_data <= (s_bus_ready && !s_bus_err && !s_bus_req_is_wr) ? s_bus_rd_data : '0;
      end
      case (state)
        IDLE: if (found) begin
          state           <= ISSUE;
          grant           <= nxt;
          rr_ptr          <= nxt;
          cnt             <= '0;
          s_bus_req_is_wr <= buf_wr[nxt];
          s_bus_addr      <= buf_addr[nxt];
          s_bus_wr_data   <= buf_wd[nxt];
          s_bus_wr_biten  <= buf_be[nxt];
        end
        ISSUE: state <= s_bus_ready ? RESP : WAIT;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
